// File: rtl/pc_seq_if.sv
// Fetch-side bundle between the PC sequencer and its front end.
// The front end is the master and drives hit, stall and redirect; the sequencer is the slave.
interface pc_seq_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             ihit;
    logic             stall;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_next_seq;
    logic             fetch_valid;
    logic [CNT_W-1:0] miss_count;
    logic             misalign_err;

    modport master (
        output ihit, stall, redirect_valid, redirect_target,
        input  pc_out, pc_next_seq, fetch_valid, miss_count, misalign_err
    );

    modport slave (
        input  ihit, stall, redirect_valid, redirect_target,
        output pc_out, pc_next_seq, fetch_valid, miss_count, misalign_err
    );
endinterface

// File: rtl/pc_seq_unit.sv
// Fetch PC sequencer: BOOT/RUN/MISS state machine with a one-entry pending redirect,
// a saturating miss-cycle counter and a sticky misaligned-target flag.
module pc_seq_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STEP         = 4,
    parameter int               ALIGN_BITS   = 2,
    parameter int               CNT_W        = 8
) (
    input  logic    clk,
    input  logic    rst,
    pc_seq_if.slave bus
);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic [1:0] {BOOT, RUN, MISS} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic             misalign_err_q, misalign_err_d;
    logic [WIDTH-1:0] tgt_aligned;
    logic [WIDTH-1:0] pc_seq;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign tgt_aligned = bus.redirect_target & ~LOW_MASK;
    assign pc_seq      = pc_q + WIDTH'(STEP);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_valid_d   = pend_valid_q;
        pend_target_d  = pend_target_q;
        miss_count_d   = miss_count_q;
        misalign_err_d = misalign_err_q;

        if (bus.redirect_valid && ((bus.redirect_target & LOW_MASK) != '0))
            misalign_err_d = 1'b1;

        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (bus.redirect_valid) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = tgt_aligned;
                end
            end
            default: begin
                if (bus.redirect_valid && !bus.stall) begin
                    pc_d         = tgt_aligned;
                    pend_valid_d = 1'b0;
                    state_d      = RUN;
                end else if (pend_valid_q && !bus.stall) begin
                    pc_d         = pend_target_q;
                    pend_valid_d = 1'b0;
                    state_d      = RUN;
                end else begin
                    // Reaching here with a redirect means stall is high: park it, newest wins.
                    if (bus.redirect_valid) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = tgt_aligned;
                    end
                    if (!bus.ihit) begin
                        if (state_q == RUN) begin
                            state_d      = MISS;
                            miss_count_d = '0;
                        end else begin
                            miss_count_d = sat_inc(miss_count_q);
                        end
                    end else begin
                        state_d = RUN;
                        if (!bus.stall) pc_d = pc_seq;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= BOOT;
            pc_q           <= RESET_VECTOR;
            pend_valid_q   <= 1'b0;
            pend_target_q  <= '0;
            miss_count_q   <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pend_valid_q   <= pend_valid_d;
            pend_target_q  <= pend_target_d;
            miss_count_q   <= miss_count_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_next_seq  = pc_seq;
    assign bus.fetch_valid  = bus.ihit & (state_q != BOOT) & ~pend_valid_q;
    assign bus.miss_count   = miss_count_q;
    assign bus.misalign_err = misalign_err_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: a reference model predicts each post-edge state into a
// scoreboard queue, directed scenarios add literal expectations on top.
module tb_pc_seq_unit;
    logic clk;
    logic rst;

    pc_seq_if #(.WIDTH(32), .CNT_W(8)) ifc ();

    pc_seq_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  miss;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_MISS = 2;

    int          m_state;
    logic [31:0] m_pc;
    logic        m_pv;
    logic [31:0] m_pt;
    logic [7:0]  m_miss;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_BOOT;
        m_pc    = 32'h0;
        m_pv    = 1'b0;
        m_pt    = 32'h0;
        m_miss  = 8'h0;
        m_err   = 1'b0;
    endtask

    // Advances the model across one rising edge for the given inputs.
    task automatic model_edge(input logic h, input logic s, input logic rv, input logic [31:0] rt);
        logic [31:0] t;
        t = {rt[31:2], 2'b00};
        if (rv && (rt[1:0] != 2'b00)) m_err = 1'b1;
        if (m_state == M_BOOT) begin
            if (rv) begin m_pv = 1'b1; m_pt = t; end
            m_state = M_RUN;
        end else if (!s && rv) begin
            m_pc = t; m_pv = 1'b0; m_state = M_RUN;
        end else if (!s && m_pv) begin
            m_pc = m_pt; m_pv = 1'b0; m_state = M_RUN;
        end else begin
            if (rv) begin m_pv = 1'b1; m_pt = t; end
            if (h) begin
                if (!s) m_pc = m_pc + 32'd4;
                m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                m_miss = 8'd0; m_state = M_MISS;
            end else if (m_miss != 8'hFF) begin
                m_miss = m_miss + 8'd1;
            end
        end
    endtask

    task automatic drive(input logic h, input logic s, input logic rv, input logic [31:0] rt);
        exp_t e;
        ifc.ihit = h; ifc.stall = s; ifc.redirect_valid = rv; ifc.redirect_target = rt;
        #1;
        chk("fetch_valid", 32'(ifc.fetch_valid), 32'(h && (m_state != M_BOOT) && !m_pv));
        chk("pc_next_seq", ifc.pc_next_seq, m_pc + 32'd4);
        model_edge(h, s, rv, rt);
        e.pc = m_pc; e.miss = m_miss; e.err = m_err;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        chk("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pc_out", ifc.pc_out, e.pc);
            chk("miss_count", 32'(ifc.miss_count), 32'(e.miss));
            chk("misalign_err", 32'(ifc.misalign_err), 32'(e.err));
        end
    endtask

    task automatic cyc(input logic h, input logic s, input logic rv, input logic [31:0] rt);
        drive(h, s, rv, rt);
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"},   ifc.pc_out, 32'h0);
        chk({tag, "_miss"}, 32'(ifc.miss_count), 32'h0);
        chk({tag, "_err"},  32'(ifc.misalign_err), 32'h0);
        chk({tag, "_fv"},   32'(ifc.fetch_valid), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ifc.ihit = 1'b1; ifc.stall = 1'b0; ifc.redirect_valid = 1'b0; ifc.redirect_target = 32'h0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_reset_state("reset");
        #2 rst = 1'b0;

        // Boot cycle then sequential fetch from the reset vector.
        drive(1, 0, 0, 32'h0);
        chk("boot_fv", 32'(ifc.fetch_valid), 32'h0);
        chk("boot_pc", ifc.pc_out, 32'h0);
        tick();
        drive(1, 0, 0, 32'h0);
        chk("run_pc0", ifc.pc_out, 32'h0);
        chk("run_fv0", 32'(ifc.fetch_valid), 32'h1);
        tick();
        drive(1, 0, 0, 32'h0);
        chk("run_pc4", ifc.pc_out, 32'h4);
        tick();
        drive(1, 0, 0, 32'h0);
        chk("run_pc8", ifc.pc_out, 32'h8);
        tick();
        cyc(1, 0, 0, 32'h0);
        chk("run_pc10", ifc.pc_out, 32'h10);

        // Miss episode at 0x10: entry cycle clears the counter, then it counts 1,2,3.
        cyc(0, 0, 0, 32'h0);
        chk("miss_entry", 32'(ifc.miss_count), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 32'h0);
            chk("miss_cnt", 32'(ifc.miss_count), 32'(i));
            chk("miss_pc", ifc.pc_out, 32'h10);
        end
        drive(1, 0, 0, 32'h0);
        chk("hit_fv", 32'(ifc.fetch_valid), 32'h1);
        tick();
        chk("after_miss_pc", ifc.pc_out, 32'h14);
        chk("miss_hold", 32'(ifc.miss_count), 32'h3);

        // Two redirects under stall: newest is kept and taken once stall drops.
        cyc(1, 1, 1, 32'h100);
        chk("stall_pc", ifc.pc_out, 32'h14);
        drive(1, 1, 1, 32'h200);
        chk("pend_fv", 32'(ifc.fetch_valid), 32'h0);
        tick();
        drive(1, 0, 0, 32'h0);
        chk("pend_fv2", 32'(ifc.fetch_valid), 32'h0);
        tick();
        chk("pend_pc", ifc.pc_out, 32'h200);
        cyc(1, 0, 0, 32'h0);

        // Misaligned redirect abandons a miss.
        cyc(0, 0, 0, 32'h0);
        cyc(0, 0, 1, 32'h203);
        chk("misal_pc", ifc.pc_out, 32'h200);
        chk("misal_err", 32'(ifc.misalign_err), 32'h1);
        drive(1, 0, 0, 32'h0);
        chk("misal_fv", 32'(ifc.fetch_valid), 32'h1);
        tick();
        chk("misal_run", ifc.pc_out, 32'h204);

        // Stall inside a miss keeps counting; hit under stall holds the PC.
        cyc(0, 0, 0, 32'h0);
        cyc(0, 1, 0, 32'h0);
        cyc(0, 1, 0, 32'h0);
        chk("stall_miss_cnt", 32'(ifc.miss_count), 32'h2);
        cyc(1, 1, 0, 32'h0);
        chk("stall_hit_pc", ifc.pc_out, 32'h204);
        cyc(1, 0, 0, 32'h0);

        // A live redirect beats an older pending one.
        cyc(1, 1, 1, 32'h300);
        cyc(1, 0, 1, 32'h400);
        chk("prio_pc", ifc.pc_out, 32'h400);
        cyc(1, 0, 0, 32'h0);
        chk("prio_next", ifc.pc_out, 32'h404);

        // Counter saturation.
        for (int i = 0; i < 300; i++) cyc(0, 0, 0, 32'h0);
        chk("miss_sat", 32'(ifc.miss_count), 32'hFF);
        cyc(1, 0, 0, 32'h0);

        // Address wrap.
        cyc(1, 0, 1, 32'hFFFF_FFFC);
        drive(1, 0, 0, 32'h0);
        chk("wrap_nseq", ifc.pc_next_seq, 32'h0);
        tick();
        chk("wrap_pc", ifc.pc_out, 32'h0);

        for (int i = 0; i < 200; i++) begin
            cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) == 0),
                logic'($urandom_range(0, 7) == 0), $urandom & 32'h0000_0FFF);
        end

        // Asynchronous reset mid-clock during a miss with a redirect parked.
        cyc(1, 0, 0, 32'h0);
        cyc(0, 0, 0, 32'h0);
        cyc(0, 0, 0, 32'h0);
        cyc(0, 1, 1, 32'h500);
        #2;
        ifc.ihit = 1'b1; ifc.stall = 1'b0; ifc.redirect_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_state("midrst");
        #1 rst = 1'b0;
        drive(1, 0, 1, 32'h600);
        chk("reboot_fv", 32'(ifc.fetch_valid), 32'h0);
        tick();
        chk("reboot_pc", ifc.pc_out, 32'h0);
        drive(1, 0, 0, 32'h0);
        chk("reboot_pend_fv", 32'(ifc.fetch_valid), 32'h0);
        tick();
        chk("reboot_pend_pc", ifc.pc_out, 32'h600);
        cyc(1, 0, 0, 32'h0);
        chk("reboot_seq", ifc.pc_out, 32'h604);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
